isq_bank: RTL
=============

Name: isq_bank

Overview:
- Parametrised, collapsing issue-queue bank of DEPTH lines.
- Each line holds a valid bit, a wait bit and an INST_WIDTH-bit instruction.
- Accepts one instruction per cycle at the tail and issues the oldest ready line (valid, wait clear) per cycle, compacting younger lines down.
- Supports operand wakeup, full flush and partial (younger-than) flush; sits between rename/dispatch and the execute-select stage.

Parameters:
INST_WIDTH, 56, instruction payload width per line
DEPTH, 16, number of lines (power of 2, >=2)
IDX_WIDTH, 4, log2(DEPTH); line index width
CNT_WIDTH, 5, IDX_WIDTH+1; occupancy count width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
ins_vld  in  1  insert request
ins_wat  in  1  wait bit of inserted instruction (1 = operands not ready)
ins_inst  in  INST_WIDTH  inserted instruction
ins_rdy  out  1  bank not full; insert accepted when ins_vld & ins_rdy
iss_rdy  in  1  downstream can take an instruction this cycle
iss_vld  out  1  a ready line exists and no flush this cycle
iss_inst  out  INST_WIDTH  instruction of selected line
iss_idx  out  IDX_WIDTH  index of selected line (0 = oldest)
wake_vec  in  DEPTH  per-line wait-clear, indexed by pre-shift line position
fls_all  in  1  flush every line
fls_yng  in  1  flush lines at index >= fls_keep
fls_keep  in  CNT_WIDTH  number of oldest lines kept on fls_yng
count  out  CNT_WIDTH  occupied lines
empty  out  1  count == 0

Behaviour:
- Reset (rst high, async): all val, wat, inst = 0; count = 0; ins_rdy = 1; iss_vld = 0; iss_inst = 0; iss_idx = 0; empty = 1.
- Occupied lines are always contiguous at indices 0..count-1; index 0 is oldest.
- Select (combinational from registered state): lowest index i with val[i] & ~wat[i].
  - iss_inst/iss_idx show that line; iss_idx = 0 and iss_inst = 0 when none.
  - iss_vld = found & ~fls_all & ~fls_yng.
- Issue fires when iss_vld & iss_rdy. Next edge: lines i+1..count-1 move to i..count-2; line count-1 is cleared (val, wat, inst = 0); count decrements.
- Insert fires when ins_vld & ins_rdy & ~fls_all & ~fls_yng. ins_rdy = (count != DEPTH); it does not depend on same-cycle issue.
  - Entry is written at index count, or count-1 if an issue also fires; val = 1, wat = ins_wat.
  - Count net change: +1, or 0 with simultaneous issue.
  - Ignored when not ready.
- Latency: inserted line with ins_wat = 0 is selectable the cycle after insertion. A wakeup in cycle t makes the line selectable in t+1.
- Wakeup: wake_vec[i] clears wat[i] using pre-shift positions.
  - When the line also shifts this cycle, the cleared wait bit moves with it.
  - Bits for invalid lines have no effect.
  - wake_vec of the issuing line is irrelevant, since the line is removed.
- fls_all: highest priority. Next state equals reset state. Insert and issue are suppressed.
- fls_yng (fls_all low):
  - Lines with index >= fls_keep are cleared; count = min(count, fls_keep).
  - fls_keep >= count has no effect on lines.
  - Insert and issue are suppressed; wakeup still applies to surviving lines.
- Flushed/cleared lines zero inst as well as val and wat.
- Full: count == DEPTH gives ins_rdy = 0. Issue still works; ins_rdy = 1 the following cycle.
- Empty: iss_vld = 0; issue is impossible.
- Reset asserted mid-operation immediately forces the reset state, regardless of pending handshakes.

Decomposition:
- Shared package isq_pkg holds INST_WIDTH/DEPTH defaults, the line field layout (val, wat, inst; wait bit at INST_WIDTH, valid at INST_WIDTH+1) and the line-width constant.
- One sub-module, isq_ent: a single line register with async active-high reset.
  - Control inputs, in priority order: clear, load-from-upper-neighbour (shift), load-insert, wakeup.
  - Instantiated DEPTH times with a generate loop.
- Priority select and shift-enable generation stay in isq_bank.

Test Plan:
- Reset, then insert 3 instructions (0xA1, 0xA2, 0xA3) with wat = 0 and iss_rdy = 0 -> count = 3. Assert iss_rdy -> issues 0xA1, 0xA2, 0xA3 on consecutive cycles with iss_idx = 0; count ends 0; empty = 1.
- Insert lines wat = 1, 0, 1 -> first issue is line 1 (iss_idx = 1). Then wake_vec = 0b001 -> next cycle issues the former line 0 at iss_idx = 0; the remaining line is still blocked.
- Fill DEPTH = 16 lines -> ins_rdy = 0 and count = 16. An insert attempted while full is dropped. One issue -> count = 15 and ins_rdy = 1 the next cycle.
- Insert + issue in the same cycle with count = 5 -> count stays 5, the new instruction lands at index 4, and younger lines shift down by one.
- count = 8, pulse fls_yng with fls_keep = 3 and ins_vld = 1 -> count = 3, no insert, iss_vld = 0 during the flush cycle. Then fls_all -> count = 0 and all lines zero.
- Assert rst asynchronously mid-stream with count = 6 -> outputs reach reset values before the next clock edge; count = 0.

Source files
------------

// File: rtl/isq_pkg.sv
// Issue-queue shared definitions: default sizes and the line field layout.
// A line is {val, wat, inst}; wait bit sits at INST_WIDTH, valid at INST_WIDTH+1.
package isq_pkg;

  localparam int ISQ_INST_WIDTH = 56;
  localparam int ISQ_DEPTH      = 16;
  localparam int ISQ_LINE_W     = ISQ_INST_WIDTH + 2;
  localparam int ISQ_WAT_POS    = ISQ_INST_WIDTH;
  localparam int ISQ_VAL_POS    = ISQ_INST_WIDTH + 1;

  typedef struct packed {
    logic                      val;
    logic                      wat;
    logic [ISQ_INST_WIDTH-1:0] inst;
  } isq_line_t;

endpackage

// File: rtl/isq_ent.sv
// Single issue-queue line register, async active-high reset.
// Ports: clr/shf/ld/wake controls (that priority), up_q/up_wake neighbour, ld_d insert data, q line.
import isq_pkg::*;

module isq_ent #(
  parameter int W = ISQ_LINE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shf,
  input  logic         ld,
  input  logic         wake,
  input  logic [W-1:0] up_q,
  input  logic         up_wake,
  input  logic [W-1:0] ld_d,
  output logic [W-1:0] q
);

  localparam int VAL = W - 1;
  localparam int WAT = W - 2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shf) begin
      // a wakeup aimed at the neighbour travels down with it
      q <= {up_q[VAL], up_q[WAT] & ~up_wake, up_q[W-3:0]};
    end else if (ld) begin
      q <= ld_d;
    end else if (wake) begin
      q[WAT] <= 1'b0;
    end
  end

endmodule

// File: rtl/isq_bank.sv
// Collapsing issue-queue bank: tail insert, oldest-ready issue, wakeup, flushes.
// Ports: ins_* insert, iss_* issue, wake_vec, fls_* flush, count/empty status.
import isq_pkg::*;

module isq_bank #(
  parameter int INST_WIDTH = ISQ_INST_WIDTH,
  parameter int DEPTH      = ISQ_DEPTH,
  parameter int IDX_WIDTH  = $clog2(DEPTH),
  parameter int CNT_WIDTH  = IDX_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ins_vld,
  input  logic                  ins_wat,
  input  logic [INST_WIDTH-1:0] ins_inst,
  output logic                  ins_rdy,
  input  logic                  iss_rdy,
  output logic                  iss_vld,
  output logic [INST_WIDTH-1:0] iss_inst,
  output logic [IDX_WIDTH-1:0]  iss_idx,
  input  logic [DEPTH-1:0]      wake_vec,
  input  logic                  fls_all,
  input  logic                  fls_yng,
  input  logic [CNT_WIDTH-1:0]  fls_keep,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty
);

  localparam int LW = INST_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);

  logic [LW-1:0]        q [DEPTH];
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] ins_pos;
  logic [IDX_WIDTH-1:0] sel;
  logic                 found;
  logic                 iss_fire;
  logic                 ins_fire;
  logic                 fls_any;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q[i][LW-1] & ~q[i][LW-2]) begin
        found = 1'b1;
        sel   = IDX_WIDTH'(i);
      end
    end
  end

  assign fls_any  = fls_all | fls_yng;
  assign iss_vld  = found & ~fls_any;
  assign iss_idx  = sel;
  assign iss_inst = found ? q[sel][INST_WIDTH-1:0] : '0;
  assign iss_fire = iss_vld & iss_rdy;
  assign ins_rdy  = (cnt != FULL);
  assign ins_fire = ins_vld & ins_rdy & ~fls_any;
  // with a same-cycle issue the tail has already slid down one slot
  assign ins_pos  = iss_fire ? cnt - ONE : cnt;
  assign count    = cnt;
  assign empty    = (cnt == '0);

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    localparam logic [CNT_WIDTH-1:0] GI = CNT_WIDTH'(g);
    logic [LW-1:0] up;
    logic          up_w;
    logic          clr;
    logic          shf;
    logic          ld;

    if (g == DEPTH - 1) begin : g_top
      assign up   = '0;
      assign up_w = 1'b0;
    end else begin : g_mid
      assign up   = q[g+1];
      assign up_w = wake_vec[g+1];
    end

    // vacated tail is cleared only if no insert refills it
    assign clr = fls_all
               | (fls_yng & (GI >= fls_keep))
               | (iss_fire & ~ins_fire & (GI == cnt - ONE));
    assign shf = iss_fire & (GI >= {1'b0, sel}) & (GI + ONE < cnt);
    assign ld  = ins_fire & (GI == ins_pos);

    isq_ent #(.W(LW)) u_ent (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .shf     (shf),
      .ld      (ld),
      .wake    (wake_vec[g]),
      .up_q    (up),
      .up_wake (up_w),
      .ld_d    ({1'b1, ins_wat, ins_inst}),
      .q       (q[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (fls_all) begin
      cnt <= '0;
    end else if (fls_yng) begin
      cnt <= (fls_keep < cnt) ? fls_keep : cnt;
    end else if (ins_fire & ~iss_fire) begin
      cnt <= cnt + ONE;
    end else if (iss_fire & ~ins_fire) begin
      cnt <= cnt - ONE;
    end
  end

endmodule
